// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller side (master) drives every control line and reads back instruction/memory status.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       br_taken;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] aluop;
  logic       lui;
  logic [1:0] mem_to_reg;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready, br_taken,
    output mem_req, mem_we, iord, ir_write, pc_write, reg_write,
           pc_src, alu_src_a, alu_src_b, aluop, lui, mem_to_reg,
           retire, illegal, state
  );

  modport slave (
    output opcode, mem_ready, br_taken,
    input  mem_req, mem_we, iord, ir_write, pc_write, reg_write,
           pc_src, alu_src_a, alu_src_b, aluop, lui, mem_to_reg,
           retire, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32I-style datapath; only write enables
// and the store retire pulse look at mem_ready/br_taken in the current cycle.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EX_R     = 4'd2,
    EX_I     = 4'd3,
    EX_LUI   = 4'd4,
    EX_AUIPC = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WR   = 4'd8,
    WB_ALU   = 4'd9,
    WB_MEM   = 4'd10,
    BRANCH   = 4'd11,
    JAL      = 4'd12,
    JALR     = 4'd13,
    TRAP     = 4'd14
  } state_t;

  state_t state_q, state_d;
  logic   is_store_q, is_store_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  assign bus.state = rst ? FETCH : state_q;

  always_comb begin
    state_d        = state_q;
    is_store_d     = is_store_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.aluop      = 2'b00;
    bus.lui        = 1'b0;
    bus.mem_to_reg = 2'b00;
    bus.retire     = 1'b0;
    bus.illegal    = 1'b0;

    // Reset masks every output so no write can slip through on the reset edge.
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'b01;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = DECODE;
          end
        end
        DECODE: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b10;
          is_store_d    = (bus.opcode == 7'b0100011);
          unique case (bus.opcode)
            7'b0110011: state_d = EX_R;
            7'b0010011: state_d = EX_I;
            7'b0110111: state_d = EX_LUI;
            7'b0010111: state_d = EX_AUIPC;
            7'b0000011,
            7'b0100011: state_d = MEM_ADDR;
            7'b1100011: state_d = BRANCH;
            7'b1101111: state_d = JAL;
            7'b1100111: state_d = JALR;
            default:    state_d = TRAP;
          endcase
        end
        EX_R: begin
          bus.alu_src_a = 2'b01;
          bus.aluop     = 2'b10;
          state_d       = WB_ALU;
        end
        EX_I: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.aluop     = 2'b11;
          state_d       = WB_ALU;
        end
        EX_LUI: begin
          bus.alu_src_b = 2'b10;
          bus.lui       = 1'b1;
          state_d       = WB_ALU;
        end
        EX_AUIPC: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b10;
          state_d       = WB_ALU;
        end
        WB_ALU: begin
          bus.reg_write = 1'b1;
          bus.retire    = 1'b1;
          state_d       = FETCH;
        end
        MEM_ADDR: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          state_d       = is_store_q ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
          if (bus.mem_ready) state_d = WB_MEM;
        end
        WB_MEM: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 2'b01;
          bus.retire     = 1'b1;
          state_d        = FETCH;
        end
        MEM_WR: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.iord    = 1'b1;
          if (bus.mem_ready) begin
            bus.retire = 1'b1;
            state_d    = FETCH;
          end
        end
        BRANCH: begin
          bus.alu_src_a = 2'b01;
          bus.aluop     = 2'b01;
          bus.pc_src    = 2'b01;
          bus.pc_write  = bus.br_taken;
          bus.retire    = 1'b1;
          state_d       = FETCH;
        end
        // The PC register still holds old_pc + 4 here, which is the link value.
        JAL: begin
          bus.pc_src     = 2'b01;
          bus.pc_write   = 1'b1;
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 2'b10;
          bus.retire     = 1'b1;
          state_d        = FETCH;
        end
        JALR: begin
          bus.alu_src_a  = 2'b01;
          bus.alu_src_b  = 2'b10;
          bus.pc_write   = 1'b1;
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 2'b10;
          bus.retire     = 1'b1;
          state_d        = FETCH;
        end
        TRAP: begin
          bus.illegal = 1'b1;
        end
        default: state_d = TRAP;
      endcase
    end
  end
endmodule
